// File: rtl/keypad_emulator.sv
// Synthesizable 4x4 matrix keypad model: closes one row/column contact per accepted request.
// Contact bounce on press and release is built only when KEYEMU_BOUNCE_EN is defined.
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 240,
  parameter int unsigned BOUNCE_TOGGLE = 40,
  parameter int unsigned GAP_CYCLES    = 2400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [31:0] hold_cycles,
  output logic        key_ready,
  output logic        busy,
  output logic        done,
  input  logic [3:0]  C,
  output logic [3:0]  R
);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef KEYEMU_BOUNCE_EN
    S_PRESS_BOUNCE,
    S_RELEASE_BOUNCE,
`endif
    S_HOLD,
    S_GAP
  } state_e;

  localparam logic [31:0] GapLast = 32'(GAP_CYCLES - 1);
`ifdef KEYEMU_BOUNCE_EN
  localparam logic [31:0] BounceLast = 32'(BOUNCE_CYCLES - 1);
  localparam logic [31:0] ToggleDiv  = 32'(BOUNCE_TOGGLE);
`endif

  if (BOUNCE_CYCLES < 1 || BOUNCE_TOGGLE < 1 || GAP_CYCLES < 1) begin : g_bad_params
    $error("keypad_emulator: BOUNCE_CYCLES, BOUNCE_TOGGLE and GAP_CYCLES must all be >= 1");
  end

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  col_q, col_d;
  logic        contact_q, contact_d;
  logic        done_q, done_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hold_q    <= 32'd1;
      row_q     <= '0;
      col_q     <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      row_q     <= row_d;
      col_q     <= col_d;
      contact_q <= contact_d;
      done_q    <= done_d;
    end
  end

  // Every state exits when cnt reaches its length minus one; the exit clears cnt for the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    hold_d    = hold_q;
    row_d     = row_q;
    col_d     = col_q;
    contact_d = contact_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (key_valid) begin
          row_d     = key_code[3:2];
          col_d     = key_code[1:0];
          hold_d    = (hold_cycles == 32'd0) ? 32'd1 : hold_cycles;
          contact_d = 1'b1;
`ifdef KEYEMU_BOUNCE_EN
          state_d   = S_PRESS_BOUNCE;
`else
          state_d   = S_HOLD;
`endif
        end
      end
`ifdef KEYEMU_BOUNCE_EN
      S_PRESS_BOUNCE: begin
        if (cnt_q == BounceLast) begin
          state_d   = S_HOLD;
          cnt_d     = '0;
          contact_d = 1'b1;
        end else if ((cnt_q + 32'd1) % ToggleDiv == 32'd0) begin
          contact_d = ~contact_q;
        end
      end
      S_RELEASE_BOUNCE: begin
        if (cnt_q == BounceLast) begin
          state_d   = S_GAP;
          cnt_d     = '0;
          contact_d = 1'b0;
        end else if ((cnt_q + 32'd1) % ToggleDiv == 32'd0) begin
          contact_d = ~contact_q;
        end
      end
`endif
      S_HOLD: begin
        if (cnt_q == hold_q - 32'd1) begin
          cnt_d     = '0;
          contact_d = 1'b0;
`ifdef KEYEMU_BOUNCE_EN
          state_d   = S_RELEASE_BOUNCE;
`else
          state_d   = S_GAP;
`endif
        end
      end
      S_GAP: begin
        if (cnt_q == GapLast) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        contact_d = 1'b0;
      end
    endcase
  end

  assign key_ready = (state_q == S_IDLE);
  assign busy      = ~key_ready;
  assign done      = done_q;

  // The closed contact passes the selected column drive straight onto the selected row.
  always_comb begin
    R = 4'b1111;
    if (contact_q) begin
      R[row_q] = C[col_q];
    end
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
Behavioural keypad model in synthesizable RTL; it acts as the 4x4 matrix keypad on the other end of the column-scan/row-sense interface. It accepts a key-press request via a valid/ready handshake. It then closes one matrix contact, with mechanical bounce, for a programmed hold time and releases it. Used for on-FPGA loopback self-test of the keypad scanner and as a synthesizable bench stimulus block.

Parameters:
BOUNCE_CYCLES, 240, length in clk cycles of each bounce window (press and release); must be >= 1
BOUNCE_TOGGLE, 40, contact toggle interval in clk cycles inside a bounce window; must be >= 1
GAP_CYCLES, 2400, minimum cycles the contact stays open after release before the next request is accepted; must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
key_valid  input  1  request strobe
key_code  input  4  requested key: [3:2] row index, [1:0] column index
hold_cycles  input  32  stable-closed duration, sampled on acceptance
key_ready  output  1  high when a request can be accepted
busy  output  1  high while a press/release sequence is in progress
done  output  1  one-cycle pulse when a sequence completes
C  input  4  column drive from scanner, active-low, one column low at a time
R  output  4  row sense to scanner, active-low, idle 4'b1111

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, contact=0, all counters 0, done=0, busy=0. key_ready=1 and R=4'b1111 from the next cycle. Reset mid-sequence aborts immediately and drops any in-flight key.
- key_ready = (state==IDLE); busy = !key_ready. Both decode from the state register.
- Acceptance: key_valid && key_ready at a clk edge.
  - Latch row, col and hold_eff = max(hold_cycles,1).
  - Enter PRESS_BOUNCE with contact=1 in the next cycle.
- key_valid while busy is ignored. No queueing. key_code/hold_cycles changes after acceptance have no effect.
- Row output is combinational from C and registered state: R[row_l] = C[col_l] when contact==1; all other R bits = 1. Multiple low C bits are handled: R[row_l] is low if C[col_l] is low.
- Counter: a single 32-bit cycle counter cnt, cleared on every state entry.
- States:
  - IDLE: contact=0. Accept -> PRESS_BOUNCE.
  - PRESS_BOUNCE: contact starts at 1 and inverts whenever cnt is a nonzero multiple of BOUNCE_TOGGLE. Lasts exactly BOUNCE_CYCLES cycles -> HOLD.
  - HOLD: contact=1 (forced on entry). Lasts hold_eff cycles -> RELEASE_BOUNCE.
  - RELEASE_BOUNCE: contact starts at 0 and inverts on the same rule. Lasts BOUNCE_CYCLES cycles -> GAP.
  - GAP: contact=0 (forced on entry). Lasts GAP_CYCLES cycles -> IDLE.
- done is registered. It is high for exactly the first IDLE cycle after GAP, during which key_ready=1; a request may be accepted in that same cycle.
- Latency, with acceptance at edge 0: contact first closes in cycle 1. done appears in cycle 1+2*BOUNCE_CYCLES+hold_eff+GAP_CYCLES.
- hold_cycles=0 is treated as 1. hold_cycles=32'hFFFFFFFF must not wrap early; compare by equality on the 32-bit counter.

Optional Feature:
KEYEMU_BOUNCE_EN.
- Defined: PRESS_BOUNCE and RELEASE_BOUNCE behave as above.
- Undefined: both bounce states are removed. Acceptance goes straight to HOLD, and HOLD goes straight to GAP, so the contact changes cleanly. done appears in cycle 1+hold_eff+GAP_CYCLES.
- Handshake, R mapping and reset behaviour are identical in both builds.

Test Plan:
The bench uses BOUNCE_CYCLES=8, BOUNCE_TOGGLE=2, GAP_CYCLES=4, with KEYEMU_BOUNCE_EN defined unless stated.
1. Reset: hold reset=0 for 3 cycles, release -> R=4'b1111, key_ready=1, busy=0, done=0.
2. Row/column mapping: key_code=4'h6, hold_cycles=10, accepted at edge 0.
   - C=4'b1011 in cycles 9-18 -> R=4'b1101.
   - C=4'b1110 or 4'b0111 in the same window -> R=4'b1111.
3. Press bounce: same request with C=4'b1011 held.
   - R[1] over cycles 1-8 is 0,0,1,1,0,0,1,1; cycles 9-18 are all 0.
   - Release cycles 19-26: R[1] is 1,1,0,0,1,1,0,0.
   - Cycles 27-30: R[1]=1.
   - done high in cycle 31 only.
4. Busy rejection: key_valid=1 with key_code=4'hF during cycles 2-30 -> key_ready=0, no new sequence starts; key 4'h6 timing is unchanged.
5. Abort: reset=0 at cycle 12, mid-HOLD -> cycle 13: R=4'b1111, key_ready=1, done never pulses.
6. Clean build (KEYEMU_BOUNCE_EN undefined): key_code=4'h0, hold_cycles=0, C=4'b1110 -> R=4'b1110 in cycle 1 only (hold treated as 1); done in cycle 1+1+4=6.
